cond_logic: RTL and testbench

//   Condition unit directly downstream of the main decoder in the single-cycle ARM core.

---
 rtl/cond_logic_pkg.sv | 27 ++
 rtl/cond_logic_flag_reg.sv | 20 ++
 rtl/cond_logic.sv | 80 ++++++++
 tb/tb_cond_logic.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cond_logic_pkg.sv
// Shared definitions for the condition unit: ARM condition-field encodings and NZCV bit positions.
package cond_logic_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic_flag_reg.sv
// Two-bit flag register with asynchronous active-low reset and load enable.
module cond_logic_flag_reg #(
  parameter logic [1:0] RST_VAL = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] d,
  output logic [1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cond_logic.sv
// Condition unit: holds NZCV, evaluates the instruction Cond field against it and
// gates the decoder's write requests into committed PC/register/memory writes.
module cond_logic
  import cond_logic_pkg::*;
#(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter bit         HAS_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       adv;
  logic       n, z, c, v;

  assign adv   = HAS_EN ? En : 1'b1;
  assign Flags = {nz_q, cv_q};
  assign n     = Flags[FLAG_N];
  assign z     = Flags[FLAG_Z];
  assign c     = Flags[FLAG_C];
  assign v     = Flags[FLAG_V];

  // Evaluated from registered flags only: an instruction never sees its own ALU result.
  always_comb begin
    CondEx = 1'b1;
    case (cond_e'(Cond))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~(c & ~z);
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = ~(~z & (n == v));
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx & adv;

  cond_logic_flag_reg #(.RST_VAL(FLAG_RST[3:2])) u_nz (
    .clk   (clk),
    .reset (reset),
    .en    (adv & FlagW[1] & CondEx),
    .d     (ALUFlags[3:2]),
    .q     (nz_q)
  );

  cond_logic_flag_reg #(.RST_VAL(FLAG_RST[1:0])) u_cv (
    .clk   (clk),
    .reset (reset),
    .en    (adv & FlagW[0] & CondEx),
    .d     (ALUFlags[1:0]),
    .q     (cv_q)
  );

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, flag write/readback, condition table and stall/reset behaviour.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic       En;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  int n_cmp = 0;
  int n_err = 0;

  cond_logic #(.FLAG_RST(4'b0000), .HAS_EN(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .En       (En),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags),
    .CondEx   (CondEx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference condition table, written from the architectural definition.
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !(fc && !fz);
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return !(!fz && (fn == fv));
      default: return 1'b1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && (RegW | MemW | PCS) === 1'b1) begin
      n_cmp++;
      assert (!$isunknown(Cond)) else begin
        n_err++;
        $error("FAIL cond_known: observed %b expected known value", Cond);
      end
    end
  end

  initial begin
    // Reset held with a pending flag write.
    reset = 1'b0; En = 1'b1; Cond = 4'b1110; ALUFlags = 4'b1111; FlagW = 2'b11;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    #1;
    check("reset_async", Flags, 4'b0000);
    tick(); tick(); tick();
    check("reset_held", Flags, 4'b0000);
    check("reset_al_condex", {3'b000, CondEx}, 4'b0001);
    FlagW = 2'b00;
    reset = 1'b1;
    tick();
    check("reset_release", Flags, 4'b0000);

    // SUBS setting Z, then BEQ / BNE.
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1'b1;
    #1;
    check("subs_regwrite", {3'b000, RegWrite}, 4'b0001);
    check("subs_flags_before_edge", Flags, 4'b0000);
    tick();
    check("subs_flags", Flags, 4'b0100);
    Cond = 4'b0000; FlagW = 2'b00; PCS = 1'b1; RegW = 1'b0;
    #1;
    check("beq_pcsrc", {3'b000, PCSrc}, 4'b0001);
    Cond = 4'b0001;
    #1;
    check("bne_pcsrc", {3'b000, PCSrc}, 4'b0000);
    PCS = 1'b0;

    // Failed condition blocks every commit and the flag write.
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0000;
    tick();
    check("load_zero", Flags, 4'b0000);
    Cond = 4'b0000; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    #1;
    check("fail_condex", {3'b000, CondEx}, 4'b0000);
    check("fail_regwrite", {3'b000, RegWrite}, 4'b0000);
    check("fail_memwrite", {3'b000, MemWrite}, 4'b0000);
    check("fail_pcsrc", {3'b000, PCSrc}, 4'b0000);
    tick();
    check("fail_flags_hold", Flags, 4'b0000);
    RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

    // Independent NZ / CV halves.
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0011;
    tick();
    check("load_0011", Flags, 4'b0011);
    FlagW = 2'b10; ALUFlags = 4'b1000;
    tick();
    check("ands_nz_only", Flags, 4'b1011);
    FlagW = 2'b01; ALUFlags = 4'b0100;
    tick();
    check("cv_only", Flags, 4'b1000);

    // Full sweep: every NZCV value against every condition code.
    for (int f = 0; f < 16; f++) begin
      Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'(f);
      tick();
      FlagW = 2'b00;
      check($sformatf("sweep_load_%0d", f), Flags, 4'(f));
      for (int cc = 0; cc < 16; cc++) begin
        Cond = 4'(cc);
        #1;
        check($sformatf("sweep_f%0d_c%0d", f, cc), {3'b000, CondEx},
              {3'b000, ref_cond(4'(cc), 4'(f))});
      end
    end

    // Stall: flags hold, memory write suppressed, others still follow the condition.
    Cond = 4'b1110; En = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0000;
    MemW = 1'b1; RegW = 1'b1; PCS = 1'b1;
    #1;
    check("stall_memwrite", {3'b000, MemWrite}, 4'b0000);
    check("stall_regwrite", {3'b000, RegWrite}, 4'b0001);
    check("stall_pcsrc", {3'b000, PCSrc}, 4'b0001);
    tick();
    check("stall_flags_hold", Flags, 4'b1111);
    En = 1'b1; FlagW = 2'b00;
    #1;
    check("unstall_memwrite", {3'b000, MemWrite}, 4'b0001);
    MemW = 1'b0; RegW = 1'b0; PCS = 1'b0;

    // Reset mid-cycle with a flag write pending: reset wins, asynchronously.
    FlagW = 2'b11; ALUFlags = 4'b1010;
    #2;
    reset = 1'b0;
    #1;
    check("midcycle_reset_async", Flags, 4'b0000);
    tick();
    check("reset_beats_write", Flags, 4'b0000);
    FlagW = 2'b00;
    reset = 1'b1;
    tick();
    check("post_reset", Flags, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
